// File: rtl/rd_bank_arbiter.sv
// Read-agent front end for the multi-bank RAM: grants at most one read per bank each cycle
// under rotating priority and issues the granted reads one cycle later with stall statistics.
module rd_bank_arbiter #(
  parameter int NB_RDAGENT   = 2,
  parameter int ADDR_WIDTH   = 8,
  parameter int SELECT_WIDTH = 4,
  parameter int WAIT_WIDTH   = 4
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [NB_RDAGENT-1:0]            s_valid,
  output logic [NB_RDAGENT-1:0]            s_ready,
  input  logic [NB_RDAGENT*ADDR_WIDTH-1:0] s_addr,
  output logic [NB_RDAGENT-1:0]            m_rden,
  output logic [NB_RDAGENT*ADDR_WIDTH-1:0] m_addr,
  output logic [NB_RDAGENT*WAIT_WIDTH-1:0] wait_cnt,
  output logic [15:0]                      coll_cnt,
  input  logic                             coll_clr
);

  localparam int PTR_W = (NB_RDAGENT > 1) ? $clog2(NB_RDAGENT) : 1;
  localparam logic [PTR_W-1:0]      PTR_LAST = PTR_W'(NB_RDAGENT - 1);
  localparam logic [WAIT_WIDTH-1:0] WAIT_MAX = {WAIT_WIDTH{1'b1}};

  logic [PTR_W-1:0]                 rr_ptr_q, rr_ptr_d;
  logic [NB_RDAGENT-1:0]            m_rden_q, m_rden_d;
  logic [NB_RDAGENT*ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
  logic [NB_RDAGENT*WAIT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
  logic [15:0]                      coll_cnt_q, coll_cnt_d;

  logic [NB_RDAGENT-1:0]   grant;
  logic [NB_RDAGENT-1:0]   deny;
  logic [SELECT_WIDTH-1:0] bank [NB_RDAGENT];
  int                      prio [NB_RDAGENT];

  // prio[i] is agent i's distance from rr_ptr in the rotation; 0 is highest priority.
  always_comb begin
    for (int i = 0; i < NB_RDAGENT; i++) begin
      bank[i] = s_addr[i*ADDR_WIDTH +: SELECT_WIDTH];
      if (i >= int'(rr_ptr_q)) begin
        prio[i] = i - int'(rr_ptr_q);
      end else begin
        prio[i] = i + NB_RDAGENT - int'(rr_ptr_q);
      end
    end
  end

  always_comb begin
    grant = s_valid;
    for (int i = 0; i < NB_RDAGENT; i++) begin
      for (int j = 0; j < NB_RDAGENT; j++) begin
        if (j != i && s_valid[j] && bank[j] == bank[i] && prio[j] < prio[i]) begin
          grant[i] = 1'b0;
        end
      end
    end
    deny = s_valid & ~grant;
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    m_rden_d   = grant;
    m_addr_d   = m_addr_q;
    wait_cnt_d = wait_cnt_q;
    coll_cnt_d = coll_cnt_q;

    if (|deny) begin
      rr_ptr_d = (rr_ptr_q == PTR_LAST) ? '0 : rr_ptr_q + PTR_W'(1);
    end

    for (int i = 0; i < NB_RDAGENT; i++) begin
      if (grant[i]) begin
        m_addr_d[i*ADDR_WIDTH +: ADDR_WIDTH] = s_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
      if (deny[i]) begin
        if (wait_cnt_q[i*WAIT_WIDTH +: WAIT_WIDTH] != WAIT_MAX) begin
          wait_cnt_d[i*WAIT_WIDTH +: WAIT_WIDTH] =
            wait_cnt_q[i*WAIT_WIDTH +: WAIT_WIDTH] + WAIT_WIDTH'(1);
        end
      end else begin
        wait_cnt_d[i*WAIT_WIDTH +: WAIT_WIDTH] = '0;
      end
    end

    if (coll_clr) begin
      coll_cnt_d = '0;
    end else if (|deny && coll_cnt_q != 16'hFFFF) begin
      coll_cnt_d = coll_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rr_ptr_q   <= '0;
      m_rden_q   <= '0;
      m_addr_q   <= '0;
      wait_cnt_q <= '0;
      coll_cnt_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      m_rden_q   <= m_rden_d;
      m_addr_q   <= m_addr_d;
      wait_cnt_q <= wait_cnt_d;
      coll_cnt_q <= coll_cnt_d;
    end
  end

  assign s_ready  = grant;
  assign m_rden   = m_rden_q;
  assign m_addr   = m_addr_q;
  assign wait_cnt = wait_cnt_q;
  assign coll_cnt = coll_cnt_q;

endmodule

// File: tb/tb_rd_bank_arbiter.sv
// Randomized and directed bench for rd_bank_arbiter (3 agents, 4 banks, 1-bit wait counters)
// checked against a queue-free priority-walk reference model.
module tb_rd_bank_arbiter;

  localparam int NB = 3;
  localparam int AW = 8;
  localparam int SW = 2;
  localparam int WW = 1;
  localparam int WMAX = (1 << WW) - 1;

  logic              aclk;
  logic              aresetn;
  logic [NB-1:0]     s_valid;
  logic [NB-1:0]     s_ready;
  logic [NB*AW-1:0]  s_addr;
  logic [NB-1:0]     m_rden;
  logic [NB*AW-1:0]  m_addr;
  logic [NB*WW-1:0]  wait_cnt;
  logic [15:0]       coll_cnt;
  logic              coll_clr;

  rd_bank_arbiter #(
    .NB_RDAGENT(NB), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW), .WAIT_WIDTH(WW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .s_valid(s_valid), .s_ready(s_ready),
    .s_addr(s_addr), .m_rden(m_rden), .m_addr(m_addr), .wait_cnt(wait_cnt),
    .coll_cnt(coll_cnt), .coll_clr(coll_clr)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int            m_rr;
  int            m_wait [NB];
  int            m_coll;
  logic [NB-1:0] e_rden;
  logic [NB*AW-1:0] e_addr;
  logic [NB-1:0] stalled;
  logic [NB-1:0] last_ready;
  int            grant_cnt [NB];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Walk agents from the rotation pointer; the first valid agent to claim a bank wins it.
  function automatic logic [NB-1:0] model_grant(input logic [NB-1:0] v,
                                                input logic [NB*AW-1:0] a, input int rr);
    bit taken [1 << SW];
    logic [NB-1:0] g;
    int idx;
    int b;
    g = '0;
    foreach (taken[k]) taken[k] = 1'b0;
    for (int k = 0; k < NB; k++) begin
      idx = (rr + k) % NB;
      if (v[idx]) begin
        b = int'(a[idx*AW +: SW]);
        if (!taken[b]) g[idx] = 1'b1;
        taken[b] = 1'b1;
      end
    end
    return g;
  endfunction

  task automatic model_reset();
    m_rr = 0;
    m_coll = 0;
    e_rden = '0;
    e_addr = '0;
    stalled = '0;
    for (int i = 0; i < NB; i++) m_wait[i] = 0;
  endtask

  function automatic logic [NB*WW-1:0] exp_wait();
    logic [NB*WW-1:0] w;
    for (int i = 0; i < NB; i++) w[i*WW +: WW] = WW'(m_wait[i]);
    return w;
  endfunction

  task automatic check_regs(input string tag);
    chk({tag, "_m_rden"}, 32'(m_rden), 32'(e_rden));
    chk({tag, "_m_addr"}, 32'(m_addr), 32'(e_addr));
    chk({tag, "_wait_cnt"}, 32'(wait_cnt), 32'(exp_wait()));
    chk({tag, "_coll_cnt"}, 32'(coll_cnt), 32'(m_coll));
  endtask

  task automatic cycle(input logic [NB-1:0] v, input logic [NB*AW-1:0] a, input logic clr);
    logic [NB-1:0] g;
    logic [NB-1:0] d;
    @(negedge aclk);
    s_valid  = v;
    s_addr   = a;
    coll_clr = clr;
    #1;
    g = model_grant(v, a, m_rr);
    last_ready = s_ready;
    chk("s_ready", 32'(s_ready), 32'(g));
    @(posedge aclk);
    d = v & ~g;
    e_rden = g;
    for (int i = 0; i < NB; i++) begin
      if (g[i]) e_addr[i*AW +: AW] = a[i*AW +: AW];
      if (d[i]) m_wait[i] = (m_wait[i] < WMAX) ? m_wait[i] + 1 : WMAX;
      else      m_wait[i] = 0;
    end
    if (clr) m_coll = 0;
    else if (d != '0 && m_coll < 65535) m_coll = m_coll + 1;
    if (d != '0) m_rr = (m_rr + 1) % NB;
    stalled = d;
    #1;
    check_regs("cyc");
  endtask

  // Stalled agents keep their request unchanged; everyone else is re-drawn.
  task automatic rand_cycle();
    logic [NB-1:0]    v;
    logic [NB*AW-1:0] a;
    v = s_valid;
    a = s_addr;
    for (int i = 0; i < NB; i++) begin
      if (!stalled[i]) begin
        v[i] = ($urandom_range(0, 99) < 65);
        a[i*AW +: AW] = AW'($urandom);
      end
    end
    cycle(v, a, $urandom_range(0, 15) == 0);
  endtask

  initial begin
    aresetn  = 1'b0;
    s_valid  = '0;
    s_addr   = '0;
    coll_clr = 1'b0;
    model_reset();
    foreach (grant_cnt[i]) grant_cnt[i] = 0;
    #1;
    chk("rst_s_ready", 32'(s_ready), 32'h0);
    check_regs("rst");
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;

    // Distinct banks 0,1,2: everybody granted, no collision, pointer stays put.
    cycle(3'b111, {8'h02, 8'h11, 8'h20}, 1'b0);
    chk("t1_ready", 32'(last_ready), 32'h7);
    chk("t1_rden", 32'(m_rden), 32'h7);
    chk("t1_coll", 32'(coll_cnt), 32'h0);

    // Agents 0 and 1 on bank 1 with pointer at 0: agent 0 wins.
    cycle(3'b011, {8'h00, 8'h45, 8'h31}, 1'b0);
    chk("t2_ready", 32'(last_ready), 32'h1);
    chk("t2_wait1", 32'(wait_cnt[1*WW +: WW]), 32'h1);
    chk("t2_coll", 32'(coll_cnt), 32'h1);
    cycle(3'b010, {8'h00, 8'h45, 8'h00}, 1'b0);
    chk("t2_ready_b", 32'(last_ready), 32'h2);
    chk("t2_wait1_b", 32'(wait_cnt[1*WW +: WW]), 32'h0);
    chk("t2_addr1", 32'(m_addr[1*AW +: AW]), 32'h45);

    // All agents held on bank 3: rotation hands out grants evenly.
    for (int c = 0; c < 6; c++) begin
      cycle(3'b111, {8'h03, 8'h07, 8'h0B}, 1'b0);
      for (int i = 0; i < NB; i++) grant_cnt[i] += int'(last_ready[i]);
      chk("t3_one_grant", 32'($countones(last_ready)), 32'h1);
    end
    for (int i = 0; i < NB; i++) chk("t3_grant_cnt", 32'(grant_cnt[i]), 32'h2);

    // Clear during a collision cycle wins over the increment.
    cycle(3'b111, {8'h03, 8'h07, 8'h0B}, 1'b1);
    chk("t5_coll_clr", 32'(coll_cnt), 32'h0);

    for (int c = 0; c < 300; c++) rand_cycle();

    // Force pending stalls, then reset asynchronously between edges.
    cycle(3'b111, {8'h01, 8'h05, 8'h09}, 1'b0);
    #2;
    aresetn = 1'b0;
    #1;
    model_reset();
    check_regs("midrst");
    s_valid  = '0;
    coll_clr = 1'b0;
    #1;
    chk("midrst_s_ready", 32'(s_ready), 32'h0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;

    // Pointer restarts at 0: agent 1 beats agent 2 on bank 1 without stalling.
    cycle(3'b110, {8'h05, 8'h09, 8'h00}, 1'b0);
    chk("post_rst_ready", 32'(last_ready), 32'h2);
    chk("post_rst_wait1", 32'(wait_cnt[1*WW +: WW]), 32'h0);

    for (int c = 0; c < 100; c++) rand_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
